// File: rtl/fetch_sequencer.sv
// Fetch-path control FSM: strobes PC->MAR->PM->MDR->IR and presents the IR to decode with valid/ready.
// Latency: start to first fetch_valid is 6 cycles; 5 cycles per instruction after each accept.
// Backpressure: PRESENT holds with stable strobes until out_ready; load_req is ignored while busy and must be held.
// Optional feature: define FETCH_SEQ_REDIRECT_EN to add redirect/redirect_addr for non-sequential fetch.
module fetch_sequencer #(
    parameter int ADDR_W    = 5,
    parameter int LAST_ADDR = 31
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic              i_halt,
    input  logic              i_load_req,
    input  logic              i_out_ready,
`ifdef FETCH_SEQ_REDIRECT_EN
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr,
`endif
    output logic              o_load_ack,
    output logic              o_fetch_valid,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic [ADDR_W-1:0] o_pc_addr_out,
    output logic              o_pc_wr,
    output logic              o_pc_rd,
    output logic              o_pc_ce,
    output logic              o_mar_wr,
    output logic              o_mar_rd,
    output logic              o_pm_rd,
    output logic              o_pm_wr,
    output logic              o_mdr_wr,
    output logic              o_mdr_rd,
    output logic              o_ir_wr,
    output logic              o_ir_rd,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_PC   = 3'd1,
        S_PC_TO_MAR = 3'd2,
        S_MEM_READ  = 3'd3,
        S_MDR_LATCH = 3'd4,
        S_IR_LATCH  = 3'd5,
        S_PRESENT   = 3'd6,
        S_PM_WRITE  = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(LAST_ADDR);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_pc_addr;
    logic [7:0]        r_fetch_count;
    logic              r_halt_pending;
    logic              r_done;
    logic              w_accept;
    logic              w_end_run;
    logic              w_redir;

    // Next-state and strobe decode; strobes follow the registered state, pc_ce also needs the accept.
    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_end_run     = 1'b0;
        w_redir       = 1'b0;
        o_pc_wr       = 1'b0;
        o_pc_rd       = 1'b0;
        o_pc_ce       = 1'b0;
        o_mar_wr      = 1'b0;
        o_mar_rd      = 1'b0;
        o_pm_rd       = 1'b0;
        o_pm_wr       = 1'b0;
        o_mdr_wr      = 1'b0;
        o_mdr_rd      = 1'b0;
        o_ir_wr       = 1'b0;
        o_ir_rd       = 1'b0;
        o_load_ack    = 1'b0;
        o_fetch_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // start wins over a simultaneous load request
                if (i_start) begin
                    w_next = S_LOAD_PC;
                end else if (i_load_req) begin
                    w_next = S_PM_WRITE;
                end
            end
            S_PM_WRITE: begin
                o_pm_wr    = 1'b1;
                o_load_ack = 1'b1;
                w_next     = S_IDLE;
            end
            S_LOAD_PC: begin
                o_pc_wr = 1'b1;
                w_next  = S_PC_TO_MAR;
            end
            S_PC_TO_MAR: begin
                o_pc_rd  = 1'b1;
                o_mar_wr = 1'b1;
                w_next   = S_MEM_READ;
            end
            S_MEM_READ: begin
                o_mar_rd = 1'b1;
                o_pm_rd  = 1'b1;
                w_next   = S_MDR_LATCH;
            end
            S_MDR_LATCH: begin
                o_pm_rd  = 1'b1;
                o_mdr_wr = 1'b1;
                w_next   = S_IR_LATCH;
            end
            S_IR_LATCH: begin
                o_mdr_rd = 1'b1;
                o_ir_wr  = 1'b1;
                w_next   = S_PRESENT;
            end
            S_PRESENT: begin
                o_ir_rd       = 1'b1;
                o_fetch_valid = 1'b1;
                if (i_out_ready) begin
                    w_accept = 1'b1;
                    // halt (pending or arriving now) beats redirect; redirect skips the end-address check
                    if (r_halt_pending || i_halt) begin
                        w_end_run = 1'b1;
`ifdef FETCH_SEQ_REDIRECT_EN
                    end else if (i_redirect) begin
                        w_redir = 1'b1;
`endif
                    end else if (r_cur_addr == LP_LAST) begin
                        w_end_run = 1'b1;
                    end
                    o_pc_ce = !w_redir;
                    if (w_end_run) begin
                        w_next = S_IDLE;
                    end else if (w_redir) begin
                        w_next = S_LOAD_PC;
                    end else begin
                        w_next = S_PC_TO_MAR;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, address tracking, halt latch, run counter and end-of-run pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_cur_addr     <= '0;
            r_pc_addr      <= '0;
            r_fetch_count  <= '0;
            r_halt_pending <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_end_run;
            if (r_state == S_IDLE) begin
                if (i_start) begin
                    r_cur_addr     <= i_start_addr;
                    r_pc_addr      <= i_start_addr;
                    r_fetch_count  <= '0;
                    r_halt_pending <= 1'b0;
                end
            end else if (i_halt) begin
                r_halt_pending <= 1'b1;
            end
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 8'd1;
`ifdef FETCH_SEQ_REDIRECT_EN
                if (w_redir) begin
                    r_cur_addr <= i_redirect_addr;
                    r_pc_addr  <= i_redirect_addr;
                end else begin
                    r_cur_addr <= r_cur_addr + 1'b1;
                end
`else
                r_cur_addr <= r_cur_addr + 1'b1;
`endif
            end
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_cur_addr    = r_cur_addr;
    assign o_pc_addr_out = r_pc_addr;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with LAST_ADDR=3: reset, sequential run, stall, halt, start/load priority.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after the edge.
// Redirect scenario is compiled only when FETCH_SEQ_REDIRECT_EN is defined.
module tb_fetch_sequencer;

    localparam int AW = 5;

    // strobe vector order: {pc_wr,pc_rd,pc_ce,mar_wr,mar_rd,pm_rd,pm_wr,mdr_wr,mdr_rd,ir_wr,ir_rd}
    localparam logic [10:0] ST_NONE    = 11'b00000000000;
    localparam logic [10:0] ST_LOAD_PC = 11'b10000000000;
    localparam logic [10:0] ST_PC_MAR  = 11'b01010000000;
    localparam logic [10:0] ST_MEM_RD  = 11'b00001100000;
    localparam logic [10:0] ST_MDR     = 11'b00000101000;
    localparam logic [10:0] ST_IR      = 11'b00000000110;
    localparam logic [10:0] ST_ACCEPT  = 11'b00100000001;
    localparam logic [10:0] ST_STALL   = 11'b00000000001;
    localparam logic [10:0] ST_PM_WR   = 11'b00000010000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          halt = 1'b0;
    logic          load_req = 1'b0;
    logic          out_ready = 1'b0;
    logic          load_ack, fetch_valid, busy, done;
    logic [AW-1:0] cur_addr, pc_addr_out;
    logic          pc_wr, pc_rd, pc_ce, mar_wr, mar_rd, pm_rd, pm_wr;
    logic          mdr_wr, mdr_rd, ir_wr, ir_rd;
    logic [7:0]    fetch_count;
    logic [10:0]   strb;
`ifdef FETCH_SEQ_REDIRECT_EN
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
`endif

    int checks = 0;
    int errors = 0;

    assign strb = {pc_wr, pc_rd, pc_ce, mar_wr, mar_rd, pm_rd, pm_wr, mdr_wr, mdr_rd, ir_wr, ir_rd};

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(AW), .LAST_ADDR(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_addr(start_addr),
        .i_halt(halt), .i_load_req(load_req), .i_out_ready(out_ready),
`ifdef FETCH_SEQ_REDIRECT_EN
        .i_redirect(redirect), .i_redirect_addr(redirect_addr),
`endif
        .o_load_ack(load_ack), .o_fetch_valid(fetch_valid), .o_cur_addr(cur_addr),
        .o_pc_addr_out(pc_addr_out), .o_pc_wr(pc_wr), .o_pc_rd(pc_rd), .o_pc_ce(pc_ce),
        .o_mar_wr(mar_wr), .o_mar_rd(mar_rd), .o_pm_rd(pm_rd), .o_pm_wr(pm_wr),
        .o_mdr_wr(mdr_wr), .o_mdr_rd(mdr_rd), .o_ir_wr(ir_wr), .o_ir_rd(ir_rd),
        .o_busy(busy), .o_done(done), .o_fetch_count(fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        #1;
        checks++; if (strb !== ST_NONE) begin errors++; $display("FAIL reset_strobes got %b want %b", strb, ST_NONE); end
        checks++; if ({busy, done, load_ack, fetch_valid} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, load_ack, fetch_valid}); end
        checks++; if ({cur_addr, pc_addr_out, fetch_count} !== 18'd0) begin errors++; $display("FAIL reset_regs got %h want 0", {cur_addr, pc_addr_out, fetch_count}); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        start = 1'b1; start_addr = 5'd7; out_ready = 1'b1;
        step(); start = 1'b0;
        step(); step();
        #1;
        checks++; if (strb !== ST_MEM_RD) begin errors++; $display("FAIL midrst_in_mem_read got %b want %b", strb, ST_MEM_RD); end
        rst = 1'b1;
        step(); rst = 1'b0;
        #1;
        checks++; if (strb !== ST_NONE) begin errors++; $display("FAIL midrst_strobes got %b want %b", strb, ST_NONE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (fetch_count !== 8'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", fetch_count); end
        checks++; if (cur_addr !== 5'd0) begin errors++; $display("FAIL midrst_cur_addr got %0d want 0", cur_addr); end
    endtask

    task automatic test_seq_run();
        logic [10:0] exp_s;
        logic        exp_fv;
        start = 1'b1; start_addr = 5'd0; out_ready = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c == 1) start = 1'b0;
            #1;
            if (c == 1) exp_s = ST_LOAD_PC;
            else if (c == 22) exp_s = ST_NONE;
            else case ((c - 2) % 5)
                0: exp_s = ST_PC_MAR;
                1: exp_s = ST_MEM_RD;
                2: exp_s = ST_MDR;
                3: exp_s = ST_IR;
                default: exp_s = ST_ACCEPT;
            endcase
            exp_fv = (c == 6 || c == 11 || c == 16 || c == 21);
            checks++; if (strb !== exp_s) begin errors++; $display("FAIL run_strobes c=%0d got %b want %b", c, strb, exp_s); end
            checks++; if (fetch_valid !== exp_fv) begin errors++; $display("FAIL run_valid c=%0d got %b want %b", c, fetch_valid, exp_fv); end
            checks++; if (done !== (c == 22)) begin errors++; $display("FAIL run_done c=%0d got %b want %b", c, done, c == 22); end
            if (exp_fv) begin
                checks++; if (cur_addr !== 5'((c - 6) / 5)) begin errors++; $display("FAIL run_cur_addr c=%0d got %0d want %0d", c, cur_addr, (c - 6) / 5); end
            end
            if (c == 1) begin
                checks++; if (fetch_count !== 8'd0) begin errors++; $display("FAIL run_count_start got %0d want 0", fetch_count); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_busy_end got %b want 0", busy); end
        checks++; if (fetch_count !== 8'd4) begin errors++; $display("FAIL run_count_end got %0d want 4", fetch_count); end
    endtask

    task automatic test_stall();
        start = 1'b1; start_addr = 5'd2; out_ready = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c == 1) start = 1'b0;
            if (c == 9) out_ready = 1'b1;
            #1;
            if (c >= 6 && c <= 8) begin
                checks++; if (strb !== ST_STALL) begin errors++; $display("FAIL stall_strobes c=%0d got %b want %b", c, strb, ST_STALL); end
                checks++; if (fetch_valid !== 1'b1 || cur_addr !== 5'd2) begin errors++; $display("FAIL stall_hold c=%0d got %b/%0d want 1/2", c, fetch_valid, cur_addr); end
            end
            if (c == 9) begin
                checks++; if (strb !== ST_ACCEPT) begin errors++; $display("FAIL stall_accept got %b want %b", strb, ST_ACCEPT); end
            end
            if (c == 10) begin
                checks++; if (fetch_valid !== 1'b0 || cur_addr !== 5'd3) begin errors++; $display("FAIL stall_after got %b/%0d want 0/3", fetch_valid, cur_addr); end
            end
            if (c == 14) begin
                checks++; if (fetch_valid !== 1'b1 || cur_addr !== 5'd3) begin errors++; $display("FAIL stall_second got %b/%0d want 1/3", fetch_valid, cur_addr); end
            end
        end
        checks++; if (done !== 1'b1 || fetch_count !== 8'd2) begin errors++; $display("FAIL stall_end got done=%b cnt=%0d want 1/2", done, fetch_count); end
    endtask

    task automatic test_halt();
        start = 1'b1; start_addr = 5'd5; out_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) start = 1'b0;
            if (c == 4) halt = 1'b1;
            if (c == 5) halt = 1'b0;
            #1;
            if (c == 4) begin
                checks++; if (strb !== ST_MDR) begin errors++; $display("FAIL halt_in_mdr got %b want %b", strb, ST_MDR); end
            end
            if (c == 6) begin
                checks++; if (fetch_valid !== 1'b1 || cur_addr !== 5'd5) begin errors++; $display("FAIL halt_present got %b/%0d want 1/5", fetch_valid, cur_addr); end
            end
        end
        checks++; if ({done, busy, fetch_valid} !== 3'b100) begin errors++; $display("FAIL halt_end got %b want 100", {done, busy, fetch_valid}); end
        checks++; if (fetch_count !== 8'd1) begin errors++; $display("FAIL halt_count got %0d want 1", fetch_count); end
    endtask

    task automatic test_start_load();
        int pm_wr_seen;
        pm_wr_seen = 0;
        start = 1'b1; load_req = 1'b1; start_addr = 5'd0; out_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) begin start = 1'b0; load_req = 1'b0; halt = 1'b1; end
            if (c == 2) halt = 1'b0;
            #1;
            if (pm_wr) pm_wr_seen++;
            if (c == 1) begin
                checks++; if (strb !== ST_LOAD_PC || load_ack !== 1'b0) begin errors++; $display("FAIL prio_load_pc got %b ack=%b want %b ack=0", strb, load_ack, ST_LOAD_PC); end
            end
        end
        checks++; if (pm_wr_seen !== 0) begin errors++; $display("FAIL prio_no_pm_wr got %0d want 0", pm_wr_seen); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL prio_run_end got done=%b busy=%b want 1/0", done, busy); end
        load_req = 1'b1;
        step(); load_req = 1'b0;
        #1;
        checks++; if (strb !== ST_PM_WR || load_ack !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL load_pulse got %b ack=%b busy=%b want %b/1/1", strb, load_ack, busy, ST_PM_WR); end
        step();
        #1;
        checks++; if (strb !== ST_NONE || load_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL load_after got %b ack=%b busy=%b want 0/0/0", strb, load_ack, busy); end
    endtask

`ifdef FETCH_SEQ_REDIRECT_EN
    task automatic test_redirect();
        start = 1'b1; start_addr = 5'd0; out_ready = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            step();
            if (c == 1) start = 1'b0;
            if (c == 16) begin redirect = 1'b1; redirect_addr = 5'd20; end
            if (c == 17) begin redirect = 1'b0; halt = 1'b1; end
            if (c == 18) halt = 1'b0;
            #1;
            if (c == 16) begin
                checks++; if (pc_ce !== 1'b0 || cur_addr !== 5'd2) begin errors++; $display("FAIL redir_accept got ce=%b addr=%0d want 0/2", pc_ce, cur_addr); end
            end
            if (c == 17) begin
                checks++; if (strb !== ST_LOAD_PC || pc_addr_out !== 5'd20 || cur_addr !== 5'd20) begin errors++; $display("FAIL redir_load_pc got %b pc=%0d cur=%0d want %b/20/20", strb, pc_addr_out, cur_addr, ST_LOAD_PC); end
            end
            if (c == 22) begin
                checks++; if (fetch_valid !== 1'b1 || cur_addr !== 5'd20) begin errors++; $display("FAIL redir_present got %b/%0d want 1/20", fetch_valid, cur_addr); end
            end
        end
        checks++; if (done !== 1'b1 || fetch_count !== 8'd4) begin errors++; $display("FAIL redir_end got done=%b cnt=%0d want 1/4", done, fetch_count); end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_reset_mid_fetch();
        test_seq_run();
        test_stall();
        test_halt();
        test_start_load();
`ifdef FETCH_SEQ_REDIRECT_EN
        test_redirect();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
